// File: rtl/sprite_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_queue: first-word-fall-through sprite draw FIFO with flush,    |
// | sticky overflow/underflow flags.                Rev 1.0               |
// +----------------------------------------------------------------------+
module sprite_queue #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          enq,
    input  logic [7:0]    enq_sprite_id,
    input  logic [15:0]   enq_sprite_x,
    input  logic [15:0]   enq_sprite_y,
    input  logic [7:0]    enq_sprite_scale,
    output logic          full,
    output logic [AW:0]   count,
    input  logic          sprite_queue_dequeue,
    output logic          sprite_queue_is_empty,
    output logic [7:0]    sprite_queue_sprite_id,
    output logic [15:0]   sprite_queue_sprite_x,
    output logic [15:0]   sprite_queue_sprite_y,
    output logic [7:0]    sprite_queue_sprite_scale,
    output logic          overflow,
    output logic          underflow,
    input  logic          clear_errors
);

    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [47:0]   mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          is_empty;
    logic          is_full;
    logic          deq_eff;
    logic          enq_acc;
    logic          wr_en;
    logic [47:0]   wdata;
    logic [47:0]   head;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_COUNT);
    assign deq_eff  = sprite_queue_dequeue && !is_empty;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign enq_acc  = enq && (!is_full || deq_eff);
    assign wr_en    = enq_acc && !flush;
    assign wdata    = {enq_sprite_id, enq_sprite_x, enq_sprite_y, enq_sprite_scale};

    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (enq_acc) wp_d = wp_q + 1'b1;
            if (deq_eff) rp_d = rp_q + 1'b1;
            if (enq_acc && !deq_eff)      count_d = count_q + 1'b1;
            else if (deq_eff && !enq_acc) count_d = count_q - 1'b1;
            if (enq && !enq_acc)                    overflow_d  = 1'b1;
            if (sprite_queue_dequeue && is_empty)   underflow_d = 1'b1;
        end
        if (clear_errors) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wp_q] <= wdata;
        end
    end

    assign head                      = mem_q[rp_q];
    assign sprite_queue_sprite_id    = head[47:40];
    assign sprite_queue_sprite_x     = head[39:24];
    assign sprite_queue_sprite_y     = head[23:8];
    assign sprite_queue_sprite_scale = head[7:0];

    assign full                  = is_full;
    assign count                 = count_q;
    assign sprite_queue_is_empty = is_empty;
    assign overflow              = overflow_q;
    assign underflow             = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sprite_queue: scoreboard bench for sprite_queue.     Rev 1.0       |
// +----------------------------------------------------------------------+
module tb_sprite_queue;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          enq   = 1'b0;
    logic [7:0]    enq_sprite_id = '0;
    logic [15:0]   enq_sprite_x = '0;
    logic [15:0]   enq_sprite_y = '0;
    logic [7:0]    enq_sprite_scale = '0;
    logic          full;
    logic [AW:0]   count;
    logic          deq = 1'b0;
    logic          is_empty;
    logic [7:0]    h_id;
    logic [15:0]   h_x;
    logic [15:0]   h_y;
    logic [7:0]    h_scale;
    logic          overflow;
    logic          underflow;
    logic          clear_errors = 1'b0;

    sprite_queue #(.DEPTH(DEPTH)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .flush                     (flush),
        .enq                       (enq),
        .enq_sprite_id             (enq_sprite_id),
        .enq_sprite_x              (enq_sprite_x),
        .enq_sprite_y              (enq_sprite_y),
        .enq_sprite_scale          (enq_sprite_scale),
        .full                      (full),
        .count                     (count),
        .sprite_queue_dequeue      (deq),
        .sprite_queue_is_empty     (is_empty),
        .sprite_queue_sprite_id    (h_id),
        .sprite_queue_sprite_x     (h_x),
        .sprite_queue_sprite_y     (h_y),
        .sprite_queue_sprite_scale (h_scale),
        .overflow                  (overflow),
        .underflow                 (underflow),
        .clear_errors              (clear_errors)
    );

    always #5 clock = ~clock;

    int          n_chk = 0;
    int          n_err = 0;
    logic [47:0] sb[$];
    int          m_count = 0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] mk(input int id);
        logic [7:0] i8;
        i8 = 8'(id);
        return {i8, 16'(10 * i8), 16'(20 * i8), 8'd8};
    endfunction

    // One clock: drive inputs, compare the head against the scoreboard on an
    // effective pop, then advance the model after the edge.
    task automatic cycle(input logic e, input logic [47:0] d, input logic q,
                         input logic f, input logic c);
        logic deq_eff, enq_acc;
        logic [47:0] exp;
        enq = e; deq = q; flush = f; clear_errors = c;
        {enq_sprite_id, enq_sprite_x, enq_sprite_y, enq_sprite_scale} = d;
        deq_eff = q && (m_count != 0);
        enq_acc = e && (m_count != DEPTH || deq_eff);
        if (!f && deq_eff) begin
            exp = sb.pop_front();
            check("head", {h_id, h_x, h_y, h_scale}, exp);
        end
        @(posedge clock); #1;
        if (f) begin
            sb.delete();
            m_count = 0;
        end else begin
            if (enq_acc) sb.push_back(d);
            if (enq_acc && !deq_eff) m_count++;
            else if (deq_eff && !enq_acc) m_count--;
            if (e && !enq_acc) m_ovf = 1'b1;
            if (q && !deq_eff) m_unf = 1'b1;
        end
        if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
        enq = 1'b0; deq = 1'b0; flush = 1'b0; clear_errors = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"}, 64'(count), 64'(m_count));
        check({tag, ".full"}, 64'(full), 64'(m_count == DEPTH));
        check({tag, ".empty"}, 64'(is_empty), 64'(m_count == 0));
        check({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
        check({tag, ".unf"}, 64'(underflow), 64'(m_unf));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (m_count > 0 && guard < 200) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            guard++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("rst.count", 64'(count), 64'd0);
        check("rst.empty", 64'(is_empty), 64'd1);
        check("rst.full", 64'(full), 64'd0);
        check("rst.head", 64'({h_id, h_x, h_y, h_scale}), 64'd0);
        check_status("rst");

        // Basic enqueue of ids 1..3
        cycle(1'b1, mk(1), 1'b0, 1'b0, 1'b0);
        check("first.empty", 64'(is_empty), 64'd0);
        check("first.id", 64'(h_id), 64'd1);
        check("first.x", 64'(h_x), 64'd10);
        check("first.y", 64'(h_y), 64'd20);
        cycle(1'b1, mk(2), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, mk(3), 1'b0, 1'b0, 1'b0);
        check("three.count", 64'(count), 64'd3);

        // Distributor pattern: idle cycle to observe head, then pop
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
            check("drain.id", 64'(h_id), 64'(i + 1));
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        check("drain.empty", 64'(is_empty), 64'd1);
        check("drain.count", 64'(count), 64'd0);
        check("drain.unf", 64'(underflow), 64'd0);

        // Fill to DEPTH
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, mk(i), 1'b0, 1'b0, 1'b0);
        check("fill.full", 64'(full), 64'd1);
        check("fill.count", 64'(count), 64'(DEPTH));
        cycle(1'b1, mk(200), 1'b0, 1'b0, 1'b0);
        check("ovf.flag", 64'(overflow), 64'd1);
        check("ovf.head", 64'(h_id), 64'd0);
        check_status("ovf");
        cycle(1'b1, mk(170), 1'b1, 1'b0, 1'b0);
        check("fullrw.count", 64'(count), 64'(DEPTH));
        check_status("fullrw");
        drain();
        check_status("filldrain");

        // Pointer wrap with a shallow occupancy
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 100; n++) begin
            cycle(1'b1, mk(n), m_count >= 3, 1'b0, 1'b0);
            if (m_count > 5) check("wrap.bound", 64'(m_count), 64'd5);
        end
        drain();
        check_status("wrap");

        // Empty corner cases
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("deqempty.unf", 64'(underflow), 64'd1);
        check("deqempty.count", 64'(count), 64'd0);
        cycle(1'b1, mk(77), 1'b1, 1'b0, 1'b0);
        check("rwempty.count", 64'(count), 64'd1);
        check("rwempty.id", 64'(h_id), 64'd77);
        cycle(1'b1, mk(200), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("clr.unf", 64'(underflow), 64'd0);
        check("clr.ovf", 64'(overflow), 64'd0);
        check_status("clr");
        drain();

        // Flush with pending entries and a same-cycle enq
        for (int i = 0; i < 10; i++) cycle(1'b1, mk(i + 30), 1'b0, 1'b0, 1'b0);
        check("preflush.count", 64'(count), 64'd10);
        cycle(1'b1, mk(99), 1'b1, 1'b1, 1'b0);
        check("flush.count", 64'(count), 64'd0);
        check("flush.empty", 64'(is_empty), 64'd1);
        check_status("flush");
        cycle(1'b1, mk(55), 1'b0, 1'b0, 1'b0);
        check("postflush.id", 64'(h_id), 64'd55);
        drain();

        // Asynchronous reset in the middle of a burst
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, mk(i + 120), 1'b0, 1'b0, 1'b0);
        check_status("preburst");
        enq = 1'b1;
        {enq_sprite_id, enq_sprite_x, enq_sprite_y, enq_sprite_scale} = mk(140);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst.count", 64'(count), 64'd0);
        check("arst.empty", 64'(is_empty), 64'd1);
        check("arst.full", 64'(full), 64'd0);
        check("arst.unf", 64'(underflow), 64'd0);
        check("arst.ovf", 64'(overflow), 64'd0);
        check("arst.head", 64'({h_id, h_x, h_y, h_scale}), 64'd0);
        enq = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        sb.delete(); m_count = 0; m_ovf = 1'b0; m_unf = 1'b0;
        cycle(1'b1, mk(9), 1'b0, 1'b0, 1'b0);
        check("postrst.id", 64'(h_id), 64'd9);
        drain();
        check_status("end");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
